// File: rtl/usart_pkg.sv
// rtl/usart_pkg.sv - shared USART constants and FSM state encoding
//
// Purpose: constants and the receiver FSM state type, kept in one package so
//          the transmitter can reuse them.
// Contents:
//   USART_OVS - oversample ticks per bit (16)
//   MID_TICK  - tick index of the mid-bit sample point (7)
//   DATA_W    - data bits per frame (8)
//   usart_state_e - IDLE, START, DATA, PARITY, STOP
package usart_pkg;

  localparam int         USART_OVS = 16;
  localparam logic [3:0] MID_TICK  = 4'd7;
  localparam int         DATA_W    = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } usart_state_e;

endpackage

// File: rtl/usart_baud_gen.sv
// rtl/usart_baud_gen.sv - free-running oversample tick divider
//
// Purpose: emits a one-cycle tick every DIV clock cycles; restart forces the
//          count back to 0 so the first tick lands DIV cycles later.
// Ports:
//   CLK     in  clock, rising edge
//   CLR     in  asynchronous active-low reset
//   restart in  resynchronise the divider to the current cycle
//   tick    out one-cycle pulse every DIV cycles
module usart_baud_gen #(
  parameter int DIV = 4
) (
  input  logic CLK,
  input  logic CLR,
  input  logic restart,
  output logic tick
);

  localparam logic [15:0] LAST = 16'(DIV - 1);

  logic [15:0] cnt_q;

  assign tick = (cnt_q == LAST);

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      cnt_q <= '0;
    end else if (restart || tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

endmodule

// File: rtl/usart_rx.sv
// rtl/usart_rx.sv - oversampling asynchronous serial receiver (8N1, or 8E1)
//
// Purpose: recovers bytes from an asynchronous serial line sampled 16 times
//          per bit, holding the last byte with status flags until read.
// Build option: define USART_RX_PARITY_EN for 8E1 frames (even parity);
//               otherwise 8N1 and parity_err is tied low.
// Ports:
//   CLK        in  sole clock, rising edge
//   CLR        in  asynchronous active-low reset
//   Rx         in  serial line, idles high, asynchronous to CLK
//   rd_en      in  consumer acknowledge; clears rx_ready and error flags
//   Data_Rx    out last received byte (LSB received first)
//   rx_ready   out a byte is held and unread
//   parity_err out held byte failed even parity
//   frame_err  out held byte had its stop bit sampled low
//   overrun    out sticky; a byte completed while rx_ready was set
module usart_rx
  import usart_pkg::*;
#(
  parameter int DIV = 4,
  parameter int OVS = 16
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic              Rx,
  input  logic              rd_en,
  output logic [DATA_W-1:0] Data_Rx,
  output logic              rx_ready,
  output logic              parity_err,
  output logic              frame_err,
  output logic              overrun
);

  // The oversample ratio is fixed; any other value falls back to the
  // package constant so the tick counter stays 4 bits wide.
  localparam logic [3:0] LAST_TICK =
    4'(((OVS == USART_OVS) ? OVS : USART_OVS) - 1);

  usart_state_e state_q, state_d;
  logic [3:0]   tick_cnt_q, tick_cnt_d;
  logic [2:0]   bit_idx_q, bit_idx_d;
  logic [DATA_W-1:0] shift_q;

  logic rx_meta, rxs, rxs_q;
  logic fall;
  logic tick;
  logic restart;
  logic shift_en;
  logic done;
  logic ack;
`ifdef USART_RX_PARITY_EN
  logic par_en;
  logic par_bit_q;
`endif

  // Two-flop synchronizer plus one delayed copy for falling-edge detection.
  // All flops reset to the idle line level so a reset never looks like an edge
  // while the line is high.
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
      rxs_q   <= 1'b1;
    end else begin
      rx_meta <= Rx;
      rxs     <= rx_meta;
      rxs_q   <= rxs;
    end
  end

  assign fall = rxs_q & ~rxs;

  usart_baud_gen #(
    .DIV(DIV)
  ) u_baud (
    .CLK    (CLK),
    .CLR    (CLR),
    .restart(restart),
    .tick   (tick)
  );

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      state_q    <= IDLE;
      tick_cnt_q <= '0;
      bit_idx_q  <= '0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      bit_idx_q  <= bit_idx_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_idx_d  = bit_idx_q;
    restart    = 1'b0;
    shift_en   = 1'b0;
    done       = 1'b0;
`ifdef USART_RX_PARITY_EN
    par_en     = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (fall) begin
          state_d    = START;
          tick_cnt_d = '0;
          restart    = 1'b1;
        end
      end
      START: begin
        // Half a bit after the edge the line must still be low; otherwise
        // the edge was a glitch and is dropped silently.
        if (tick) begin
          if (tick_cnt_q == MID_TICK) begin
            tick_cnt_d = '0;
            bit_idx_d  = '0;
            state_d    = rxs ? IDLE : DATA;
          end else begin
            tick_cnt_d = tick_cnt_q + 4'd1;
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (tick_cnt_q == LAST_TICK) begin
            tick_cnt_d = '0;
            shift_en   = 1'b1;
            if (bit_idx_q == 3'd7) begin
`ifdef USART_RX_PARITY_EN
              state_d = PARITY;
`else
              state_d = STOP;
`endif
            end else begin
              bit_idx_d = bit_idx_q + 3'd1;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 4'd1;
          end
        end
      end
`ifdef USART_RX_PARITY_EN
      PARITY: begin
        if (tick) begin
          if (tick_cnt_q == LAST_TICK) begin
            tick_cnt_d = '0;
            par_en     = 1'b1;
            state_d    = STOP;
          end else begin
            tick_cnt_d = tick_cnt_q + 4'd1;
          end
        end
      end
`else
      PARITY: begin
        state_d = IDLE;
      end
`endif
      STOP: begin
        // Leave at mid stop bit so a start edge at the end of the stop bit
        // (zero idle time) is still caught from IDLE.
        if (tick) begin
          if (tick_cnt_q == LAST_TICK) begin
            tick_cnt_d = '0;
            done       = 1'b1;
            state_d    = IDLE;
          end else begin
            tick_cnt_d = tick_cnt_q + 4'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // LSB arrives first, so bits enter at the top and move down.
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      shift_q <= '0;
    end else if (shift_en) begin
      shift_q <= {rxs, shift_q[DATA_W-1:1]};
    end
  end

  assign ack = rd_en & rx_ready;

  // A completing byte takes priority over a same-cycle acknowledge: the new
  // byte is delivered and the acknowledge only suppresses the overrun.
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      Data_Rx   <= '0;
      rx_ready  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else if (done) begin
      Data_Rx   <= shift_q;
      rx_ready  <= 1'b1;
      frame_err <= ~rxs;
      overrun   <= rx_ready ? ~rd_en : overrun;
    end else if (ack) begin
      rx_ready  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end
  end

`ifdef USART_RX_PARITY_EN
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      par_bit_q  <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      if (par_en) begin
        par_bit_q <= rxs;
      end
      if (done) begin
        parity_err <= ^{shift_q, par_bit_q};
      end else if (ack) begin
        parity_err <= 1'b0;
      end
    end
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_usart_rx.sv
// tb/tb_usart_rx.sv - self-checking bench for usart_rx
module tb_usart_rx;

  localparam int DIV = 4;
  localparam int BIT = DIV * 16;
`ifdef USART_RX_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic       CLK = 1'b0;
  logic       CLR = 1'b0;
  logic       Rx = 1'b1;
  logic       rd_en = 1'b0;
  logic [7:0] Data_Rx;
  logic       rx_ready;
  logic       parity_err;
  logic       frame_err;
  logic       overrun;

  int n_tests = 0;
  int n_fail = 0;

  always #5 CLK = ~CLK;

  usart_rx #(
    .DIV(DIV),
    .OVS(16)
  ) dut (
    .CLK       (CLK),
    .CLR       (CLR),
    .Rx        (Rx),
    .rd_en     (rd_en),
    .Data_Rx   (Data_Rx),
    .rx_ready  (rx_ready),
    .parity_err(parity_err),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  initial begin
    repeat (95000) @(negedge CLK);
    $display("FAIL watchdog: run still going after 95000 cycles, want finished");
    $fatal(1, "watchdog");
  end

  // Drive one frame on the line: start, 8 data bits LSB first, optional even
  // parity (inverted when bad_par), then the given stop level. Line left high.
  task automatic send_frame(input logic [7:0] d, input logic bad_par, input logic stop);
    Rx = 1'b0;
    repeat (BIT) @(negedge CLK);
    for (int i = 0; i < 8; i++) begin
      Rx = d[i];
      repeat (BIT) @(negedge CLK);
    end
    if (PAR) begin
      Rx = (^d) ^ bad_par;
      repeat (BIT) @(negedge CLK);
    end
    Rx = stop;
    repeat (BIT) @(negedge CLK);
    Rx = 1'b1;
  endtask

  task automatic wait_ready(input string name, input int max_cycles);
    int c;
    c = 0;
    while (rx_ready !== 1'b1 && c < max_cycles) begin
      @(negedge CLK);
      c++;
    end
    n_tests++;
    if (rx_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_timeout: rx_ready=%b after %0d cycles, want 1", name, rx_ready, c);
    end
  endtask

  task automatic pulse_rd();
    rd_en = 1'b1;
    @(negedge CLK);
    rd_en = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_reset();
    CLR = 1'b0;
    Rx = 1'b1;
    repeat (3) @(negedge CLK);
    n_tests++; if (Data_Rx !== 8'h00) begin n_fail++; $display("FAIL reset_data got %h want 00", Data_Rx); end
    n_tests++; if (rx_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got %b want 0", rx_ready); end
    n_tests++; if (parity_err !== 1'b0) begin n_fail++; $display("FAIL reset_perr got %b want 0", parity_err); end
    n_tests++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_ferr got %b want 0", frame_err); end
    n_tests++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_ovr got %b want 0", overrun); end
    CLR = 1'b1;
    repeat (10) @(negedge CLK);
  endtask

  task automatic test_basic();
    int lat;
    int mid_stop;
    mid_stop = (PAR ? 10 : 9) * BIT + BIT / 2;
    lat = 0;
    fork
      send_frame(8'h09, 1'b0, 1'b1);
      begin
        while (rx_ready !== 1'b1 && lat < 2000) begin
          @(negedge CLK);
          lat++;
        end
      end
    join
    n_tests++; if (lat < mid_stop || lat > mid_stop + 6) begin n_fail++; $display("FAIL basic_latency got %0d cycles want %0d..%0d", lat, mid_stop, mid_stop + 6); end
    n_tests++; if (rx_ready !== 1'b1) begin n_fail++; $display("FAIL basic_ready got %b want 1", rx_ready); end
    n_tests++; if (Data_Rx !== 8'h09) begin n_fail++; $display("FAIL basic_data got %h want 09", Data_Rx); end
    n_tests++; if (parity_err !== 1'b0) begin n_fail++; $display("FAIL basic_perr got %b want 0", parity_err); end
    n_tests++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL basic_ferr got %b want 0", frame_err); end
    pulse_rd();
    n_tests++; if (rx_ready !== 1'b0) begin n_fail++; $display("FAIL basic_rd_ready got %b want 0", rx_ready); end
    repeat (20) @(negedge CLK);
  endtask

  task automatic test_parity();
    send_frame(8'h09, 1'b1, 1'b1);
    wait_ready("parity", 100);
    n_tests++; if (Data_Rx !== 8'h09) begin n_fail++; $display("FAIL parity_data got %h want 09", Data_Rx); end
    n_tests++; if (parity_err !== PAR) begin n_fail++; $display("FAIL parity_perr got %b want %b", parity_err, PAR); end
    pulse_rd();
    n_tests++; if (rx_ready !== 1'b0) begin n_fail++; $display("FAIL parity_rd_ready got %b want 0", rx_ready); end
    n_tests++; if (parity_err !== 1'b0) begin n_fail++; $display("FAIL parity_rd_perr got %b want 0", parity_err); end
    repeat (20) @(negedge CLK);
  endtask

  task automatic test_false_start();
    Rx = 1'b0;
    repeat (20) @(negedge CLK);
    Rx = 1'b1;
    repeat (12 * BIT) @(negedge CLK);
    n_tests++; if (rx_ready !== 1'b0) begin n_fail++; $display("FAIL false_start_ready got %b want 0", rx_ready); end
    n_tests++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL false_start_ferr got %b want 0", frame_err); end
    send_frame(8'hA5, 1'b0, 1'b1);
    wait_ready("false_start_next", 100);
    n_tests++; if (Data_Rx !== 8'hA5) begin n_fail++; $display("FAIL false_start_data got %h want a5", Data_Rx); end
    n_tests++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL false_start_next_ferr got %b want 0", frame_err); end
    pulse_rd();
    repeat (20) @(negedge CLK);
  endtask

  task automatic test_overrun();
    send_frame(8'h3C, 1'b0, 1'b1);
    send_frame(8'hC3, 1'b0, 1'b1);
    wait_ready("overrun", 100);
    n_tests++; if (Data_Rx !== 8'hC3) begin n_fail++; $display("FAIL overrun_data got %h want c3", Data_Rx); end
    n_tests++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL overrun_flag got %b want 1", overrun); end
    pulse_rd();
    n_tests++; if (rx_ready !== 1'b0) begin n_fail++; $display("FAIL overrun_rd_ready got %b want 0", rx_ready); end
    n_tests++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL overrun_rd_flag got %b want 0", overrun); end
    repeat (20) @(negedge CLK);
  endtask

  task automatic test_frame_err_clr();
    send_frame(8'h55, 1'b0, 1'b0);
    wait_ready("frame_err", 100);
    n_tests++; if (Data_Rx !== 8'h55) begin n_fail++; $display("FAIL ferr_data got %h want 55", Data_Rx); end
    n_tests++; if (frame_err !== 1'b1) begin n_fail++; $display("FAIL ferr_flag got %b want 1", frame_err); end
    repeat (10) @(negedge CLK);
    // 0xF8 keeps the line high from data bit 3 onward, so the abandoned frame
    // leaves no falling edge behind the reset.
    fork
      send_frame(8'hF8, 1'b0, 1'b1);
      begin
        repeat (4 * BIT + BIT / 2) @(negedge CLK);
        CLR = 1'b0;
        @(negedge CLK);
        n_tests++; if ({Data_Rx, rx_ready, parity_err, frame_err, overrun} !== 12'h000) begin n_fail++; $display("FAIL clr_outputs got data=%h rdy=%b pe=%b fe=%b ov=%b want all 0", Data_Rx, rx_ready, parity_err, frame_err, overrun); end
        CLR = 1'b1;
      end
    join
    repeat (2 * BIT) @(negedge CLK);
    n_tests++; if (rx_ready !== 1'b0) begin n_fail++; $display("FAIL clr_abandon_ready got %b want 0", rx_ready); end
    send_frame(8'h81, 1'b0, 1'b1);
    wait_ready("clr_next", 100);
    n_tests++; if (Data_Rx !== 8'h81) begin n_fail++; $display("FAIL clr_next_data got %h want 81", Data_Rx); end
    n_tests++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL clr_next_ferr got %b want 0", frame_err); end
    pulse_rd();
    repeat (20) @(negedge CLK);
  endtask

  task automatic test_stuck_low();
    Rx = 1'b0;
    wait_ready("stuck", 14 * BIT);
    n_tests++; if (Data_Rx !== 8'h00) begin n_fail++; $display("FAIL stuck_data got %h want 00", Data_Rx); end
    n_tests++; if (frame_err !== 1'b1) begin n_fail++; $display("FAIL stuck_ferr got %b want 1", frame_err); end
    pulse_rd();
    repeat (14 * BIT) @(negedge CLK);
    n_tests++; if (rx_ready !== 1'b0) begin n_fail++; $display("FAIL stuck_second_ready got %b want 0", rx_ready); end
    Rx = 1'b1;
    repeat (20) @(negedge CLK);
    send_frame(8'h5A, 1'b0, 1'b1);
    wait_ready("stuck_next", 100);
    n_tests++; if (Data_Rx !== 8'h5A) begin n_fail++; $display("FAIL stuck_next_data got %h want 5a", Data_Rx); end
    pulse_rd();
    repeat (20) @(negedge CLK);
  endtask

  task automatic test_back_to_back();
    fork
      begin
        send_frame(8'h00, 1'b0, 1'b1);
        send_frame(8'hFF, 1'b0, 1'b1);
      end
      begin
        wait_ready("b2b_first", 14 * BIT);
        n_tests++; if (Data_Rx !== 8'h00) begin n_fail++; $display("FAIL b2b_first_data got %h want 00", Data_Rx); end
        pulse_rd();
        wait_ready("b2b_second", 14 * BIT);
        n_tests++; if (Data_Rx !== 8'hFF) begin n_fail++; $display("FAIL b2b_second_data got %h want ff", Data_Rx); end
        n_tests++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL b2b_overrun got %b want 0", overrun); end
        pulse_rd();
      end
    join
    repeat (20) @(negedge CLK);
  endtask

  task automatic test_random();
    logic [7:0] d;
    logic       bad_par;
    logic       stop;
    int         gap;
    for (int k = 0; k < 8; k++) begin
      d       = 8'($urandom);
      bad_par = 1'($urandom_range(0, 1));
      stop    = ($urandom_range(0, 3) != 0);
      gap     = $urandom_range(0, 30);
      send_frame(d, bad_par, stop);
      wait_ready("rand", 100);
      n_tests++; if (Data_Rx !== d) begin n_fail++; $display("FAIL rand%0d_data got %h want %h", k, Data_Rx, d); end
      n_tests++; if (parity_err !== (PAR & bad_par)) begin n_fail++; $display("FAIL rand%0d_perr got %b want %b", k, parity_err, PAR & bad_par); end
      n_tests++; if (frame_err !== !stop) begin n_fail++; $display("FAIL rand%0d_ferr got %b want %b", k, frame_err, !stop); end
      n_tests++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL rand%0d_ovr got %b want 0", k, overrun); end
      pulse_rd();
      n_tests++; if (rx_ready !== 1'b0) begin n_fail++; $display("FAIL rand%0d_rd_ready got %b want 0", k, rx_ready); end
      repeat (gap + 4) @(negedge CLK);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_false_start();
    test_overrun();
    test_frame_err_clr();
    test_stuck_low();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/usart_rx.md
USART_RX -- requirements
Module: usart_rx

Interface
REQ-001 SHALL have parameter DIV, default 4: CLK cycles per oversample tick; legal range 2..65535.
REQ-002 SHALL have parameter OVS, default 16: oversample ticks per bit; fixed at 16.
REQ-003 SHALL have port CLK  in  1  sole clock; all state on rising edge.
REQ-004 SHALL have port CLR  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port Rx  in  1  serial line; idles high; asynchronous to CLK.
REQ-006 SHALL have port rd_en  in  1  consumer acknowledge; clears rx_ready and error flags.
REQ-007 SHALL have port Data_Rx  out  8  last received byte; LSB received first.
REQ-008 SHALL have port rx_ready  out  1  level; a byte is held and unread.
REQ-009 SHALL have port parity_err  out  1  held byte failed parity.
REQ-010 SHALL have port frame_err  out  1  held byte had stop bit sampled low.
REQ-011 SHALL have port overrun  out  1  sticky; a byte completed while rx_ready was 1.

Function
REQ-012 SHALL pass Rx through a 2-flop synchronizer; all decisions use the synchronized value rxs (2-cycle input latency).
REQ-013 SHALL generate a 1-cycle tick every DIV CLK cycles from a free-running divider, restarted to 0 on the IDLE->START transition.
REQ-014 SHALL implement FSM IDLE, START, DATA, PARITY, STOP with a 4-bit tick counter and 3-bit bit index.
REQ-015 IDLE: on rxs falling (1->0) SHALL go to START with tick counter 0.
REQ-016 START: at tick count 7 (mid-bit), rxs=0 SHALL go to DATA with counter reset; rxs=1 is a false start and SHALL return to IDLE with no flag change.
REQ-017 DATA: SHALL sample rxs every 16 ticks at mid-bit into a shift register, LSB first; after bit index 7 SHALL go to PARITY (macro defined) or STOP.
REQ-018 PARITY: SHALL sample one bit; error when XOR of 8 data bits and parity bit is 1 (even parity).
REQ-019 STOP: at mid-bit SHALL load Data_Rx, set rx_ready, and set parity_err/frame_err from this frame in the same cycle, then go to IDLE. A low stop bit still delivers the byte with frame_err=1.
REQ-020 The STOP->IDLE transition SHALL occur at mid stop bit so that a start edge half a bit later is detected.
REQ-021 rd_en while rx_ready=1 SHALL clear rx_ready, parity_err, frame_err and overrun next cycle; rd_en while rx_ready=0 SHALL have no effect.
REQ-022 On completion while rx_ready=1 and no same-cycle rd_en: SHALL overwrite Data_Rx, set overrun. With same-cycle rd_en: the new byte wins, rx_ready stays 1, overrun=0.
REQ-023 Rx held low indefinitely SHALL yield one frame with frame_err=1, then no new frame until rxs returns high.

Reset
REQ-024 CLR=0 SHALL asynchronously force: FSM IDLE, counters 0, synchronizer flops 1, Data_Rx=8'h00, rx_ready=0, parity_err=0, frame_err=0, overrun=0.
REQ-025 CLR asserted mid-frame SHALL abandon the frame; after release the block SHALL wait for a fresh falling edge.

Configuration
REQ-026 With USART_RX_PARITY_EN defined: frame = start, 8 data, even parity, stop (8E1).
REQ-027 Without it: 8N1, PARITY state unreachable, parity_err tied 0.

Structure
REQ-028 Package usart_pkg SHALL hold the FSM state enum, OVS=16, mid-sample constant 7, and data width 8 for reuse by the transmitter.
REQ-029 The tick divider SHALL be sub-module usart_baud_gen (inputs CLK, CLR, restart; output tick).

Verification (DIV=4, 64 CLK cycles/bit)
REQ-030 8E1 frame 0x09, parity 0, stop 1 -> Data_Rx=0x09, rx_ready=1, parity_err=0, frame_err=0, ~2 cycles after mid stop bit.
REQ-031 0x09 with parity bit 1 -> Data_Rx=0x09, parity_err=1; rd_en pulse -> rx_ready=0, parity_err=0.
REQ-032 Rx low 20 cycles then high -> no rx_ready, FSM back in IDLE; following 0xA5 frame received correctly.
REQ-033 0x3C then 0xC3 with no rd_en -> Data_Rx=0xC3, overrun=1; rd_en clears all flags.
REQ-034 0x55 with stop bit 0 -> Data_Rx=0x55, frame_err=1; CLR pulsed during next frame's data bit 3 -> all outputs 0, next clean 0x81 frame received.
REQ-035 Back-to-back 0x00, 0xFF with zero idle between frames -> both received in order, with rd_en issued after each.
